// File: rtl/rx_rate_limiter_if.sv
// Word stream between MAC rx, rate limiter and input arbiter.
// wr is a one-cycle write strobe; rdy means the sink can take a word.
interface rx_rate_limiter_if #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH/8
);
  logic [DATA_WIDTH-1:0] data;
  logic [CTRL_WIDTH-1:0] ctrl;
  logic                  wr;
  logic                  rdy;

  modport master (
    output data, ctrl, wr,
    input  rdy
  );

  modport slave (
    input  data, ctrl, wr,
    output rdy
  );
endinterface

// File: rtl/rx_rate_limiter.sv
// Token-bucket packet policer on the rx word stream.
// Define RX_RATE_LIMITER_STATS_EN to build the pass/drop counters.
module rx_rate_limiter #(
  parameter int DATA_WIDTH  = 64,
  parameter int CTRL_WIDTH  = DATA_WIDTH/8,
  parameter int TOKEN_WIDTH = 20
) (
  input  logic                   clk,
  input  logic                   reset,
  rx_rate_limiter_if.slave       in_if,
  rx_rate_limiter_if.master      out_if,
  input  logic                   limiter_en,
  input  logic [15:0]            rate_inc,
  input  logic [TOKEN_WIDTH-1:0] bucket_max,
  output logic [TOKEN_WIDTH-1:0] tokens,
  output logic [31:0]            pkt_passed,
  output logic [31:0]            pkt_dropped
);
  localparam int SW = TOKEN_WIDTH + 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PASS,
    S_DROP
  } state_t;

  state_t                 r_state;
  logic [DATA_WIDTH-1:0]  r_out_data;
  logic [CTRL_WIDTH-1:0]  r_out_ctrl;
  logic                   r_out_wr;
  logic [TOKEN_WIDTH-1:0] r_tokens;

  logic          w_hdr;
  logic          w_end;
  logic          w_fits;
  logic          w_in_rdy;
  logic          w_acc;
  logic          w_hdr_acc;
  logic          w_fwd;
  logic          w_stray;
  logic [15:0]   w_len;
  logic [SW-1:0] w_debit;
  logic [SW-1:0] w_sum;
  logic [SW-1:0] w_max;

  assign w_hdr  = in_if.ctrl == {CTRL_WIDTH{1'b1}};
  assign w_end  = in_if.ctrl != '0;
  assign w_len  = in_if.data[15:0];
  assign w_fits = !limiter_en ||
                  (SW'(r_tokens) >= SW'(w_len));

  // A header about to be dropped never waits on downstream
  always_comb begin
    w_in_rdy = out_if.rdy;
    unique case (1'b1)
      r_state == S_DROP:
        w_in_rdy = 1'b1;
      r_state == S_IDLE && w_hdr && !w_fits:
        w_in_rdy = 1'b1;
      default: ;
    endcase
  end

  assign w_acc     = in_if.wr && w_in_rdy;
  assign w_hdr_acc = w_acc && r_state == S_IDLE && w_hdr;
  assign w_stray   = w_acc && r_state == S_IDLE && !w_hdr;
  assign w_fwd     = w_acc && (r_state == S_PASS ||
                     (r_state == S_IDLE && w_hdr && w_fits));

  assign w_debit = (w_hdr_acc && w_fits && limiter_en) ?
                   SW'(w_len) : '0;
  // Debit never exceeds tokens, so the sum cannot underflow
  assign w_sum   = SW'(r_tokens) + SW'(rate_inc) - w_debit;
  assign w_max   = SW'(bucket_max);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_out_wr   <= 1'b0;
      r_out_data <= '0;
      r_out_ctrl <= '0;
    end else begin
      r_out_wr <= w_fwd;
      if (w_fwd) begin
        r_out_data <= in_if.data;
        r_out_ctrl <= in_if.ctrl;
      end
      unique case (r_state)
        S_IDLE:
          if (w_hdr_acc)
            r_state <= w_fits ? S_PASS : S_DROP;
        S_PASS, S_DROP:
          if (w_acc && w_end)
            r_state <= S_IDLE;
        default:
          r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_tokens <= '0;
    else if (!limiter_en)
      r_tokens <= bucket_max;
    else if (w_sum > w_max)
      r_tokens <= bucket_max;
    else
      r_tokens <= w_sum[TOKEN_WIDTH-1:0];
  end

`ifdef RX_RATE_LIMITER_STATS_EN
  logic [31:0] r_passed;
  logic [31:0] r_dropped;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_passed  <= '0;
      r_dropped <= '0;
    end else begin
      if (w_hdr_acc && w_fits)
        r_passed <= r_passed + 32'd1;
      if ((w_hdr_acc && !w_fits) || w_stray)
        r_dropped <= r_dropped + 32'd1;
    end
  end

  assign pkt_passed  = r_passed;
  assign pkt_dropped = r_dropped;
`else
  assign pkt_passed  = '0;
  assign pkt_dropped = '0;
`endif

  assign in_if.rdy   = w_in_rdy;
  assign out_if.data = r_out_data;
  assign out_if.ctrl = r_out_ctrl;
  assign out_if.wr   = r_out_wr;
  assign tokens      = r_tokens;
endmodule

// File: tb/tb_rx_rate_limiter.sv
// Directed bench for rx_rate_limiter.
// Counter expectations follow RX_RATE_LIMITER_STATS_EN.
module tb_rx_rate_limiter;
  localparam int DW = 64;
  localparam int CW = 8;
  localparam int TW = 20;
`ifdef RX_RATE_LIMITER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          limiter_en;
  logic [15:0]   rate_inc;
  logic [TW-1:0] bucket_max;
  logic [TW-1:0] tokens;
  logic [31:0]   pkt_passed;
  logic [31:0]   pkt_dropped;

  int checks = 0;
  int failures = 0;

  rx_rate_limiter_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) in_if ();
  rx_rate_limiter_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW)) out_if ();

  rx_rate_limiter #(
    .DATA_WIDTH (DW),
    .CTRL_WIDTH (CW),
    .TOKEN_WIDTH(TW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_if      (in_if),
    .out_if     (out_if),
    .limiter_en (limiter_en),
    .rate_inc   (rate_inc),
    .bucket_max (bucket_max),
    .tokens     (tokens),
    .pkt_passed (pkt_passed),
    .pkt_dropped(pkt_dropped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] hdr(input logic [15:0] id,
                                      input logic [15:0] len);
    return {16'hC0DE, id, 16'h0000, len};
  endfunction

  // Present one word, clock it in, then check the output register
  task automatic word(input string tag,
                      input logic [63:0] d,
                      input logic [7:0] c,
                      input bit fwd);
    in_if.data = d;
    in_if.ctrl = c;
    in_if.wr   = 1'b1;
    tick();
    in_if.wr   = 1'b0;
    chk({tag, "_wr"}, 64'(out_if.wr), 64'(fwd));
    if (fwd) begin
      chk({tag, "_data"}, out_if.data, d);
      chk({tag, "_ctrl"}, 64'(out_if.ctrl), 64'(c));
    end
  endtask

  initial begin
    reset       = 1'b1;
    limiter_en  = 1'b1;
    rate_inc    = 16'd10;
    bucket_max  = 20'd50;
    in_if.data  = '0;
    in_if.ctrl  = '0;
    in_if.wr    = 1'b0;
    out_if.rdy  = 1'b1;
    tick();
    tick();
    chk("rst_out_wr", 64'(out_if.wr), 64'd0);
    chk("rst_out_data", out_if.data, 64'd0);
    chk("rst_out_ctrl", 64'(out_if.ctrl), 64'd0);
    chk("rst_tokens", 64'(tokens), 64'd0);
    chk("rst_passed", 64'(pkt_passed), 64'd0);
    chk("rst_dropped", 64'(pkt_dropped), 64'd0);
    reset = 1'b0;

    // Refill: 10 per cycle, capped at 50
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk($sformatf("fill_%0d", i), 64'(tokens),
          64'(i * 10 > 50 ? 50 : i * 10));
    end
    chk("idle_in_rdy", 64'(in_if.rdy), 64'd1);

    // Limiter disabled: everything passes, tokens track max
    limiter_en = 1'b0;
    word("p0_w0", hdr(16'h0001, 16'd60), 8'hFF, 1'b1);
    word("p0_w1", 64'h1111_2222_3333_4444, 8'h00, 1'b1);
    word("p0_w2", 64'h5555_6666_7777_8888, 8'h00, 1'b1);
    word("p0_w3", 64'h9999_AAAA_BBBB_CCCC, 8'h0F, 1'b1);
    chk("p0_tokens", 64'(tokens), 64'd50);
    tick();
    chk("p0_idle_wr", 64'(out_if.wr), 64'd0);
    chk("p0_passed", 64'(pkt_passed), STATS ? 64'd1 : 64'd0);

    // Preload 100 tokens, then enforce with no refill
    bucket_max = 20'd100;
    tick();
    limiter_en = 1'b1;
    rate_inc   = 16'd0;
    chk("p1_pre_tokens", 64'(tokens), 64'd100);
    word("p1_w0", hdr(16'h0002, 16'd60), 8'hFF, 1'b1);
    chk("p1_tokens", 64'(tokens), 64'd40);
    word("p1_w1", 64'hDEAD_BEEF_0000_0001, 8'h00, 1'b1);
    word("p1_w2", 64'hDEAD_BEEF_0000_0002, 8'h00, 1'b1);
    word("p1_w3", 64'hDEAD_BEEF_0000_0003, 8'h01, 1'b1);

    // 40 < 60: dropped, and accepted even with downstream stalled
    out_if.rdy = 1'b0;
    in_if.data = hdr(16'h0003, 16'd60);
    in_if.ctrl = 8'hFF;
    #1;
    chk("p2_hdr_in_rdy", 64'(in_if.rdy), 64'd1);
    word("p2_w0", hdr(16'h0003, 16'd60), 8'hFF, 1'b0);
    chk("p2_drop_in_rdy", 64'(in_if.rdy), 64'd1);
    word("p2_w1", 64'h0BAD_0BAD_0000_0001, 8'h00, 1'b0);
    word("p2_w2", 64'h0BAD_0BAD_0000_0002, 8'h80, 1'b0);
    out_if.rdy = 1'b1;
    tick();
    chk("p2_idle_wr", 64'(out_if.wr), 64'd0);
    chk("p2_tokens", 64'(tokens), 64'd40);
    chk("p2_dropped", 64'(pkt_dropped), STATS ? 64'd1 : 64'd0);
    chk("p2_passed", 64'(pkt_passed), STATS ? 64'd2 : 64'd0);

    // tokens == byte_len is enough to pass
    word("p3_w0", hdr(16'h0004, 16'd40), 8'hFF, 1'b1);
    chk("p3_tokens", 64'(tokens), 64'd0);
    word("p3_w1", 64'hFEED_FACE_0000_0001, 8'h01, 1'b1);

    // Backpressure mid-packet
    limiter_en = 1'b0;
    word("p4_w0", hdr(16'h0005, 16'd70), 8'hFF, 1'b1);
    word("p4_w1", 64'hA5A5_0000_0000_0001, 8'h00, 1'b1);
    out_if.rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("p4_stall_rdy_%0d", i), 64'(in_if.rdy), 64'd0);
      tick();
      chk($sformatf("p4_stall_wr_%0d", i), 64'(out_if.wr), 64'd0);
    end
    out_if.rdy = 1'b1;
    #1;
    chk("p4_resume_rdy", 64'(in_if.rdy), 64'd1);
    word("p4_w2", 64'hA5A5_0000_0000_0002, 8'h00, 1'b1);
    word("p4_w3", 64'hA5A5_0000_0000_0003, 8'h00, 1'b1);
    word("p4_w4", 64'hA5A5_0000_0000_0004, 8'h03, 1'b1);
    tick();
    chk("p4_idle_wr", 64'(out_if.wr), 64'd0);
    chk("p4_passed", 64'(pkt_passed), STATS ? 64'd4 : 64'd0);

    // Reset on word 2; the remainder arrives as stray words
    word("p5_w0", hdr(16'h0006, 16'd60), 8'hFF, 1'b1);
    reset = 1'b1;
    word("p5_w1", 64'h7777_0000_0000_0001, 8'h00, 1'b0);
    reset = 1'b0;
    word("p5_w2", 64'h7777_0000_0000_0002, 8'h00, 1'b0);
    word("p5_w3", 64'h7777_0000_0000_0003, 8'h00, 1'b0);
    word("p5_w4", 64'h7777_0000_0000_0004, 8'h02, 1'b0);
    tick();
    chk("p5_idle_wr", 64'(out_if.wr), 64'd0);
    chk("p5_dropped", 64'(pkt_dropped), STATS ? 64'd3 : 64'd0);
    chk("p5_passed", 64'(pkt_passed), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rx_rate_limiter.md
RX_RATE_LIMITER -- requirements
Module: rx_rate_limiter

Interface
REQ-001 Parameter DATA_WIDTH, default 64, data path word width.
REQ-002 Parameter CTRL_WIDTH, default DATA_WIDTH/8, control lane width.
REQ-003 Parameter TOKEN_WIDTH, default 20, token bucket width.
REQ-004 clk  input  1  single clock; all logic is clocked on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_data  input  DATA_WIDTH  word from the MAC group rx output.
REQ-007 in_ctrl  input  CTRL_WIDTH  control lane for in_data.
REQ-008 in_wr  input  1  input word valid.
REQ-009 in_rdy  output  1  block can accept a word this cycle.
REQ-010 out_data  output  DATA_WIDTH  word to the downstream input arbiter.
REQ-011 out_ctrl  output  CTRL_WIDTH  control lane for out_data.
REQ-012 out_wr  output  1  output word valid.
REQ-013 out_rdy  input  1  downstream can accept a word.
REQ-014 limiter_en  input  1  1 = enforce the token bucket; 0 = pass all packets.
REQ-015 rate_inc  input  16  tokens (bytes) added per clk cycle.
REQ-016 bucket_max  input  TOKEN_WIDTH  token ceiling.
REQ-017 tokens  output  TOKEN_WIDTH  current token count.
REQ-018 pkt_passed  output  32  count of forwarded packets.
REQ-019 pkt_dropped  output  32  count of dropped packets.

Function
REQ-020 A packet SHALL start with a module header word: in_ctrl == 8'hFF, byte length in in_data[15:0]. It SHALL end on the first following word with in_ctrl != 0.
REQ-021 The FSM SHALL have three states: IDLE, PASS and DROP. Reset state is IDLE.
REQ-022 In IDLE, a header word with in_wr=1 SHALL trigger the drop/pass decision: go to PASS if limiter_en=0 or tokens >= byte_len, otherwise go to DROP.
REQ-023 In IDLE, a non-header word with in_wr=1 SHALL be discarded and counted as a drop, and the FSM SHALL stay in IDLE.
REQ-024 In PASS and DROP, an end word accepted with in_wr=1 SHALL return the FSM to IDLE on the next cycle.
REQ-025 Words of a passing packet, including its header, SHALL appear on out_data/out_ctrl with out_wr=1 exactly one cycle after they are accepted. Output registers SHALL be used.
REQ-026 Words of a dropped packet SHALL never assert out_wr.
REQ-027 in_rdy SHALL be high in DROP, and in IDLE when the current header decides to drop. Otherwise in_rdy SHALL equal out_rdy.
REQ-028 Upstream SHALL NOT assert in_wr while in_rdy=0. The block's behaviour for in_wr asserted with in_rdy=0 is undefined.
REQ-029 Each cycle, tokens_next SHALL be min(tokens + rate_inc - debit, bucket_max). Compute this in TOKEN_WIDTH+2 bits. debit is byte_len on a passing header with limiter_en=1, otherwise 0.
REQ-030 When limiter_en=0, tokens SHALL be loaded with bucket_max every cycle.
REQ-031 A change of limiter_en or bucket_max mid-packet SHALL NOT alter that packet's decision.
REQ-032 pkt_passed SHALL increment on each header that goes to PASS. pkt_dropped SHALL increment on each header that goes to DROP and on each stray word discarded in IDLE. Both counters SHALL wrap modulo 2^32.

Reset
REQ-033 Reset SHALL set: state IDLE, out_wr=0, out_data=0, out_ctrl=0, tokens=0, pkt_passed=0, pkt_dropped=0.
REQ-034 Reset asserted mid-packet SHALL abandon the packet without emitting further words. Words arriving after reset before the next header SHALL be handled as stray words per REQ-023.

Configuration
REQ-035 When macro RX_RATE_LIMITER_STATS_EN is defined, pkt_passed and pkt_dropped SHALL be implemented per REQ-032.
REQ-036 When RX_RATE_LIMITER_STATS_EN is undefined, pkt_passed and pkt_dropped SHALL be constant 0, no counter flops SHALL exist, and data path behaviour SHALL be unchanged.

Verification
REQ-037 limiter_en=0, 4-word packet with byte_len 60, out_rdy=1 -> 4 words out, each 1 cycle late and bit-identical; pkt_passed=1.
REQ-038 limiter_en=1, rate_inc=0, tokens=100, header byte_len 60 -> packet passes and tokens reads 40 on the next cycle; a second 60-byte packet -> dropped with zero out_wr and pkt_dropped=1.
REQ-039 rate_inc=10, bucket_max=50, idle 10 cycles after reset -> tokens reads 10, 20, 30, 40, 50, then holds at 50.
REQ-040 Passing packet with out_rdy deasserted for 3 cycles mid-packet -> in_rdy=0 for those 3 cycles; no word lost or duplicated.
REQ-041 Reset pulsed on word 2 of a 5-word passing packet -> out_wr=0 after reset; remaining 3 words discarded; pkt_dropped=3 (macro defined) or 0 (macro undefined).
